fpnew_i2f_arbiter: RTL
======================

Name: fpnew_i2f_arbiter

Overview:
- Shares one int-to-float cast unit among NumReq independent requesters (e.g. a vector lane cluster).
- Round-robin arbitration with grant lock while the downstream handshake is pending.
- Credit-limits in-flight operations to MaxInFlight.
- Routes each result back to its originating requester via the requester index carried in the cast unit's tag.

Parameters:
- NumReq, 4, number of requesters (2..16).
- MaxInFlight, 4, max accepted-but-not-returned ops (≥ cast unit pipeline depth + 1).
- SRC_WIDTH, 64, integer operand width.
- DST_WIDTH, 32, FP result width.
- IDX_WIDTH, $clog2(NumReq), localparam, requester index / tag width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request accepted (one-hot or zero).
- req_operand_i  in  NumReq*SRC_WIDTH  integer operands.
- req_rnd_mode_i  in  NumReq*3  rounding modes (roundmode_e).
- req_op_mod_i  in  NumReq  1 = unsigned cast.
- req_int_fmt_i  in  NumReq*2  int_format_e per requester.
- rsp_valid_o  out  NumReq  per-requester result valid.
- rsp_ready_i  in  NumReq  per-requester result ready.
- rsp_result_o  out  DST_WIDTH  result (shared bus, qualified by rsp_valid_o).
- rsp_status_o  out  5  status_t (shared).
- cu_valid_o / cu_ready_i  out/in  1  cast-unit input handshake.
- cu_operand_o, cu_rnd_mode_o, cu_op_mod_o, cu_int_fmt_o  out  -  muxed request fields.
- cu_tag_o  out  IDX_WIDTH  granted requester index.
- cu_valid_i / cu_ready_o  in/out  1  cast-unit output handshake.
- cu_result_i  in  DST_WIDTH  cast-unit result.
- cu_status_i  in  5  cast-unit status.
- cu_tag_i  in  IDX_WIDTH  returned index.
- flush_i  in  1  kill all in-flight ops.
- cu_flush_o  out  1  flush to cast unit.
- busy_o  out  1  in_flight != 0 or lock held.

Behaviour:
- Reset values (async, rst_i=1): rr_ptr=0, lock=0, locked_idx=0, in_flight=0. All *_valid_o and req_ready_o = 0, cu_flush_o = 0, busy_o = 0.
- Issue states:
  - IDLE: grant the first requester with req_valid_i=1, searching from rr_ptr upward (mod NumReq).
  - Assert cu_valid_o only if in_flight < MaxInFlight (credit available). With no credit, cu_valid_o=0 and nothing is granted.
  - If cu_valid_o & cu_ready_i: req_ready_o[g]=1 in the same cycle (zero added latency), rr_ptr <= g+1 (wrap to 0 past NumReq-1).
  - If cu_valid_o & !cu_ready_i: go to LOCKED, locked_idx <= g.
- LOCKED: cu_valid_o=1 with fields of locked_idx regardless of other requesters. Requesters must hold valid/data stable (protocol rule; the bench asserts it). On cu_ready_i: req_ready_o[locked_idx]=1, rr_ptr <= locked_idx+1, return to IDLE.
- Credit counter: in_flight +1 on an issue handshake, -1 on a response handshake (rsp_valid_o & rsp_ready_i). Both in the same cycle: unchanged. Never exceeds MaxInFlight and never underflows; an underflow attempt is an assertion failure.
- Response routing:
  - rsp_valid_o[cu_tag_i] = cu_valid_i; other bits 0.
  - cu_ready_o = rsp_ready_i[cu_tag_i].
  - rsp_result_o and rsp_status_o pass through combinationally (0 cycles added).
  - Result order per requester is issue order; the cast unit is in-order.
- flush_i (synchronous, 1 cycle):
  - cu_flush_o = flush_i, combinational.
  - Next cycle: in_flight=0, lock=0, state IDLE, rr_ptr unchanged.
  - During the flush cycle, cu_valid_o=0, req_ready_o=0, rsp_valid_o=0.
- Reset mid-operation: all state cleared immediately; outstanding ops are lost and the cast unit is reset by the same rst_i.
- Single requester: issues back-to-back at 1 op/cycle while credits allow.

Decomposition:
- fpnew_pkg gets no new types.
- Local typedef req_t {operand, rnd_mode, op_mod, int_fmt} shared by input arrays and muxed output.
- One sub-module, fpnew_rr_arb_lock: round-robin pointer plus lock logic, output grant index and valid. The top module holds the credit counter, muxes and response demux.

Test Plan:
- Single requester 1, operand 32'h0000_0005, INT32 signed, RNE → cu_tag_o=1; rsp_valid_o=4'b0010 with result 32'h40A0_0000, status 0.
- All 4 requesters valid continuously, cu_ready_i=1 → grant order 0,1,2,3,0,… (one grant per cycle); in_flight saturates at 4 and cu_valid_o drops until responses drain.
- Requester 2 granted, cu_ready_i=0 for 3 cycles while requester 0 raises valid → cu_tag_o stays 2 and fields stable. Requester 2 accepted on cycle 4; next grant is 3, then 0.
- Response for tag 3 with rsp_ready_i[3]=0 for 2 cycles → cu_ready_o=0 and in_flight unchanged. Simultaneous issue and response cycle leaves in_flight constant.
- flush_i with in_flight=3, lock held → cu_flush_o=1 same cycle; next cycle in_flight=0, busy_o=0, and new grants resume from the preserved rr_ptr.
- rst_i asserted mid-LOCKED, asynchronous (not clock-aligned) → all outputs 0 immediately; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/fpnew_i2f_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpnew_i2f_arbiter_pkg                                            |
// | Purpose : Shared types for the int-to-float cast-unit arbiter: rounding    |
// |           mode, integer format, FP status flags, arbiter FSM states and a  |
// |           modulo-N increment helper for the round-robin pointer.           |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fpnew_i2f_arbiter_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [1:0] {
    INT8  = 2'd0,
    INT16 = 2'd1,
    INT32 = 2'd2,
    INT64 = 2'd3
  } int_format_e;

  typedef struct packed {
    logic nv;  // invalid
    logic dz;  // divide by zero
    logic of;  // overflow
    logic uf;  // underflow
    logic nx;  // inexact
  } status_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // (idx + 1) mod n, for idx < n
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_rr_arb_lock.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpnew_rr_arb_lock                                                |
// | Purpose : Round-robin requester selection with a grant lock that holds the |
// |           chosen index while the downstream handshake is stalled.          |
// | Ports   : clk_i, rst_i (async, active high), flush_i                       |
// |           req_valid_i[NumReq]  requester valids                            |
// |           credit_i             a new issue is allowed (credit available)   |
// |           ready_i              downstream accepts the grant                |
// |           valid_o / idx_o      grant valid and granted index               |
// |           lock_o               a stalled grant is being held               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fpnew_rr_arb_lock
  import fpnew_i2f_arbiter_pkg::*;
#(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NumReq)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [NumReq-1:0]    req_valid_i,
  input  logic                 credit_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [IDX_WIDTH-1:0] idx_o,
  output logic                 lock_o
);

  arb_state_e           state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] locked_idx_q, locked_idx_d;

  logic                 found;
  logic [IDX_WIDTH-1:0] search_idx;
  logic [IDX_WIDTH:0]   cand;
  logic                 valid;
  logic [IDX_WIDTH-1:0] idx;

  // First valid requester at or after rr_ptr, wrapping modulo NumReq.
  // cand is one bit wider so rr_ptr + i never overflows before the wrap.
  always_comb begin
    found      = 1'b0;
    search_idx = '0;
    cand       = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_WIDTH+1)'(i);
      if (cand >= (IDX_WIDTH+1)'(NumReq)) cand = cand - (IDX_WIDTH+1)'(NumReq);
      if (!found && req_valid_i[cand[IDX_WIDTH-1:0]]) begin
        found      = 1'b1;
        search_idx = cand[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    locked_idx_d = locked_idx_q;
    valid        = 1'b0;
    idx          = search_idx;

    unique case (state_q)
      ARB_IDLE: begin
        valid = found & credit_i;
        idx   = search_idx;
      end
      // Credit was available on entry and can only grow until the grant
      // completes, so the held request needs no fresh credit check.
      ARB_LOCKED: begin
        valid = 1'b1;
        idx   = locked_idx_q;
      end
      default: ;
    endcase

    // Outputs are forced quiet during reset and during a flush cycle.
    if (rst_i || flush_i) valid = 1'b0;

    if (flush_i) begin
      state_d = ARB_IDLE;
    end else if (valid && ready_i) begin
      state_d  = ARB_IDLE;
      rr_ptr_d = IDX_WIDTH'(wrap_inc(32'(idx), NumReq));
    end else if (valid) begin
      state_d      = ARB_LOCKED;
      locked_idx_d = idx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      locked_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      locked_idx_q <= locked_idx_d;
    end
  end

  assign valid_o = valid;
  assign idx_o   = idx;
  assign lock_o  = (state_q == ARB_LOCKED);

endmodule
`default_nettype wire

// File: rtl/fpnew_i2f_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fpnew_i2f_arbiter                                                |
// | Purpose : Shares one int-to-float cast unit among NumReq requesters with   |
// |           round-robin arbitration, grant lock, in-flight credit limiting   |
// |           and tag-based response routing.                                  |
// | Ports   : clk_i, rst_i (async, active high), flush_i / cu_flush_o          |
// |           req_*      per-requester request side (valid/ready + fields)     |
// |           rsp_*      per-requester response side, shared result/status    |
// |           cu_*_o/i   cast-unit input handshake (fields + tag)              |
// |           cu_*_i/o   cast-unit output handshake (result, status, tag)      |
// |           busy_o     ops in flight or a grant is locked                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fpnew_i2f_arbiter
  import fpnew_i2f_arbiter_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxInFlight = 4,
  parameter int unsigned SRC_WIDTH   = 64,
  parameter int unsigned DST_WIDTH   = 32,
  localparam int unsigned IDX_WIDTH  = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*SRC_WIDTH-1:0] req_operand_i,
  input  logic [NumReq*3-1:0]     req_rnd_mode_i,
  input  logic [NumReq-1:0]       req_op_mod_i,
  input  logic [NumReq*2-1:0]     req_int_fmt_i,
  output logic [NumReq-1:0]       rsp_valid_o,
  input  logic [NumReq-1:0]       rsp_ready_i,
  output logic [DST_WIDTH-1:0]    rsp_result_o,
  output status_t                 rsp_status_o,
  output logic                    cu_valid_o,
  input  logic                    cu_ready_i,
  output logic [SRC_WIDTH-1:0]    cu_operand_o,
  output roundmode_e              cu_rnd_mode_o,
  output logic                    cu_op_mod_o,
  output int_format_e             cu_int_fmt_o,
  output logic [IDX_WIDTH-1:0]    cu_tag_o,
  input  logic                    cu_valid_i,
  output logic                    cu_ready_o,
  input  logic [DST_WIDTH-1:0]    cu_result_i,
  input  status_t                 cu_status_i,
  input  logic [IDX_WIDTH-1:0]    cu_tag_i,
  input  logic                    flush_i,
  output logic                    cu_flush_o,
  output logic                    busy_o
);

  localparam int unsigned CNT_WIDTH = $clog2(MaxInFlight + 1);

  typedef struct packed {
    logic [SRC_WIDTH-1:0] operand;
    roundmode_e           rnd_mode;
    logic                 op_mod;
    int_format_e          int_fmt;
  } req_t;

  req_t                 req_arr [NumReq];
  req_t                 sel;
  logic [CNT_WIDTH-1:0] in_flight;
  logic                 credit;
  logic                 gnt_valid;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic                 lock;
  logic                 issue_hs;
  logic                 rsp_hs;
  logic                 tag_ok;

  always_comb begin
    for (int i = 0; i < int'(NumReq); i++) begin
      req_arr[i].operand  = req_operand_i[i*SRC_WIDTH +: SRC_WIDTH];
      req_arr[i].rnd_mode = roundmode_e'(req_rnd_mode_i[i*3 +: 3]);
      req_arr[i].op_mod   = req_op_mod_i[i];
      req_arr[i].int_fmt  = int_format_e'(req_int_fmt_i[i*2 +: 2]);
    end
  end

  assign credit = (in_flight < CNT_WIDTH'(MaxInFlight));

  fpnew_rr_arb_lock #(
    .NumReq    (NumReq),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .credit_i    (credit),
    .ready_i     (cu_ready_i),
    .valid_o     (gnt_valid),
    .idx_o       (gnt_idx),
    .lock_o      (lock)
  );

  // ---------------- issue side ----------------
  assign sel           = req_arr[gnt_idx];
  assign cu_valid_o    = gnt_valid;
  assign cu_operand_o  = sel.operand;
  assign cu_rnd_mode_o = sel.rnd_mode;
  assign cu_op_mod_o   = sel.op_mod;
  assign cu_int_fmt_o  = sel.int_fmt;
  assign cu_tag_o      = gnt_idx;
  assign issue_hs      = gnt_valid & cu_ready_i;
  assign req_ready_o   = issue_hs ? (NumReq'(1) << gnt_idx) : '0;

  // ---------------- response side ----------------
  // A tag beyond NumReq-1 can only exist for non-power-of-two NumReq.
  if (NumReq == (1 << IDX_WIDTH)) begin : g_tag_full
    assign tag_ok = 1'b1;
  end else begin : g_tag_range
    assign tag_ok = (cu_tag_i < IDX_WIDTH'(NumReq));
  end

  always_comb begin
    rsp_valid_o = '0;
    cu_ready_o  = 1'b0;
    if (tag_ok && !rst_i) begin
      cu_ready_o = rsp_ready_i[cu_tag_i];
      if (!flush_i) rsp_valid_o[cu_tag_i] = cu_valid_i;
    end
  end

  assign rsp_result_o = cu_result_i;
  assign rsp_status_o = cu_status_i;
  assign rsp_hs       = |(rsp_valid_o & rsp_ready_i);

  // ---------------- credit counter ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_flight <= '0;
    end else if (flush_i) begin
      in_flight <= '0;
    end else if (issue_hs && !rsp_hs) begin
      in_flight <= in_flight + CNT_WIDTH'(1);
    end else if (!issue_hs && rsp_hs && (in_flight != '0)) begin
      in_flight <= in_flight - CNT_WIDTH'(1);
    end
  end

  assign cu_flush_o = flush_i;
  assign busy_o     = (in_flight != '0) | lock;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (rsp_hs && !issue_hs && !flush_i) |-> (in_flight != '0));

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    in_flight <= CNT_WIDTH'(MaxInFlight));

endmodule
`default_nettype wire
